// File: rtl/led_mux_pkg.sv
// Shared types and helpers for the multiplexed RGB LED PWM driver.
package led_mux_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam logic OFF_A = 1'b0;
    localparam logic OFF_B = 1'b1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int addr_w(input int n, input int c);
        return cnt_w(n * c);
    endfunction

endpackage

// File: rtl/led_mux_tick_gen.sv
// Prescaler producing one PWM tick every PRESCALE clocks; held at zero by restart.
module led_mux_tick_gen
    import led_mux_pkg::*;
#(
    parameter int PRESCALE = 64
) (
    input  logic clk30,
    input  logic rst,
    input  logic restart_i,
    output logic tick_o
);

    localparam int             PS_W    = cnt_w(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q;
    logic [PS_W-1:0] ps_d;

    assign tick_o = (ps_q == PS_LAST);

    always_comb begin
        ps_d = ps_q + PS_W'(1);
        if (restart_i || tick_o) begin
            ps_d = '0;
        end
    end

    always_ff @(posedge clk30) begin
        if (rst) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

endmodule

// File: rtl/led_mux_pwm.sv
// Per-LED, per-colour PWM driver for a multiplexed RGB LED bank with
// double-buffered duty registers and registered pin outputs.
module led_mux_pwm
    import led_mux_pkg::*;
#(
    parameter int NUM_LEDS    = 7,
    parameter int NUM_COLORS  = 3,
    parameter int PWM_BITS    = 8,
    parameter int PRESCALE    = 64,
    parameter int DEAD_CYCLES = 4,
    localparam int ADDR_W     = addr_w(NUM_LEDS, NUM_COLORS)
) (
    input  logic                  clk30,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [PWM_BITS-1:0]   cfg_wdata,
    output logic                  frame_start,
    output logic [NUM_LEDS-1:0]   led_rgb_multiplex_a,
    output logic [NUM_COLORS-1:0] led_rgb_multiplex_b
);

    localparam int NUM_ENTRIES = NUM_LEDS * NUM_COLORS;
    localparam int DEAD_W      = cnt_w(DEAD_CYCLES);
    localparam int COL_W       = cnt_w(NUM_COLORS);

    localparam logic [DEAD_W-1:0]   DEAD_LAST   = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [COL_W-1:0]    COL_LAST    = COL_W'(NUM_COLORS - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST    = '1;
    localparam logic [ADDR_W:0]     ENTRIES_LIM = (ADDR_W + 1)'(NUM_ENTRIES);

    state_t              state_q, state_d;
    logic [DEAD_W-1:0]   dead_q, dead_d;
    logic [COL_W-1:0]    color_q, color_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic                commit;
    logic                commit_q;
    logic                tick;

    logic [PWM_BITS-1:0] pending_q [NUM_ENTRIES];
    logic [PWM_BITS-1:0] active_q  [NUM_ENTRIES];

    logic [NUM_LEDS-1:0]   a_q, a_d;
    logic [NUM_COLORS-1:0] b_q, b_d;
    logic                  fs_q, fs_d;
    logic [ADDR_W-1:0]     idx;

    led_mux_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk30     (clk30),
        .rst       (rst),
        .restart_i (state_q != DRIVE),
        .tick_o    (tick)
    );

    always_comb begin
        state_d = state_q;
        dead_d  = dead_q;
        color_d = color_q;
        pwm_d   = pwm_q;
        commit  = 1'b0;
        case (state_q)
            BLANK: begin
                if (dead_q == DEAD_LAST) begin
                    state_d = DRIVE;
                    dead_d  = '0;
                    pwm_d   = '0;
                    commit  = (color_q == '0);
                end else begin
                    dead_d = dead_q + DEAD_W'(1);
                end
            end
            DRIVE: begin
                if (tick) begin
                    pwm_d = pwm_q + PWM_BITS'(1);
                    if (pwm_q == PWM_LAST) begin
                        state_d = BLANK;
                        color_d = (color_q == COL_LAST) ? '0 : color_q + COL_W'(1);
                    end
                end
            end
            default: state_d = BLANK;
        endcase
    end

    // Pin values are computed from the current state and registered, so the
    // pins trail the FSM by one clock and a/b always switch together.
    always_comb begin
        a_d  = {NUM_LEDS{OFF_A}};
        b_d  = {NUM_COLORS{OFF_B}};
        fs_d = 1'b0;
        idx  = '0;
        if (state_q == DRIVE) begin
            b_d[color_q] = 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                idx    = ADDR_W'(i * NUM_COLORS) + ADDR_W'(color_q);
                a_d[i] = (active_q[idx] > pwm_q);
            end
            fs_d = commit_q;
        end
    end

    always_ff @(posedge clk30) begin
        if (rst) begin
            state_q  <= BLANK;
            dead_q   <= '0;
            color_q  <= '0;
            pwm_q    <= '0;
            commit_q <= 1'b0;
            a_q      <= {NUM_LEDS{OFF_A}};
            b_q      <= {NUM_COLORS{OFF_B}};
            fs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            dead_q   <= dead_d;
            color_q  <= color_d;
            pwm_q    <= pwm_d;
            commit_q <= commit;
            a_q      <= a_d;
            b_q      <= b_d;
            fs_q     <= fs_d;
        end
    end

    // Commit copies the pre-edge pending values; a write on the commit edge
    // therefore waits for the following frame.
    always_ff @(posedge clk30) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                pending_q[i] <= '0;
                active_q[i]  <= '0;
            end
        end else begin
            if (commit) begin
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    active_q[i] <= pending_q[i];
                end
            end
            if (cfg_we && ({1'b0, cfg_addr} < ENTRIES_LIM)) begin
                pending_q[cfg_addr] <= cfg_wdata;
            end
        end
    end

    assign frame_start         = fs_q;
    assign led_rgb_multiplex_a = a_q;
    assign led_rgb_multiplex_b = b_q;

endmodule

// File: tb/tb_led_mux_pwm.sv
// Randomised scoreboard bench for led_mux_pwm against a frame-position model.
module tb_led_mux_pwm;

    localparam int NL    = 7;
    localparam int NC    = 3;
    localparam int PB    = 4;
    localparam int PS    = 1;
    localparam int DC    = 2;
    localparam int NE    = NL * NC;
    localparam int AW    = 5;
    localparam int PHASE = DC + PS * (1 << PB);
    localparam int FRAME = NC * PHASE;

    logic          clk30 = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [PB-1:0] cfg_wdata;
    logic          frame_start;
    logic [NL-1:0] led_a;
    logic [NC-1:0] led_b;

    always #5 clk30 = ~clk30;

    led_mux_pwm #(
        .NUM_LEDS    (NL),
        .NUM_COLORS  (NC),
        .PWM_BITS    (PB),
        .PRESCALE    (PS),
        .DEAD_CYCLES (DC)
    ) dut (
        .clk30               (clk30),
        .rst                 (rst),
        .cfg_we              (cfg_we),
        .cfg_addr            (cfg_addr),
        .cfg_wdata           (cfg_wdata),
        .frame_start         (frame_start),
        .led_rgb_multiplex_a (led_a),
        .led_rgb_multiplex_b (led_b)
    );

    typedef struct packed {
        logic [NL-1:0] a;
        logic [NC-1:0] b;
        logic          fs;
        logic          rs;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: outputs follow from the clock count since reset.
    int   pend[NE];
    int   act[NE];
    int   k;
    bit   started = 1'b0;

    always @(posedge clk30) begin
        exp_t e;
        int   pos, in_ph, col, tk;
        e = '0;
        e.b = '1;
        if (rst) begin
            started = 1'b1;
            k = 0;
            for (int i = 0; i < NE; i++) begin
                pend[i] = 0;
                act[i]  = 0;
            end
            e.rs = 1'b1;
            exp_q.push_back(e);
        end else if (started) begin
            k++;
            pos   = k - 1;
            in_ph = pos % PHASE;
            col   = (pos / PHASE) % NC;
            if (in_ph >= DC) begin
                tk = (in_ph - DC) / PS;
                e.b[col] = 1'b0;
                for (int i = 0; i < NL; i++) e.a[i] = (act[i * NC + col] > tk);
                e.fs = (col == 0) && (in_ph == DC);
            end
            exp_q.push_back(e);
            if (k % FRAME == DC) begin
                for (int i = 0; i < NE; i++) act[i] = pend[i];
            end
            if (cfg_we && cfg_addr < NE) pend[cfg_addr] = cfg_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    int since_fs = -1;

    always @(negedge clk30) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("led_a", 32'(led_a), 32'(e.a));
            check("led_b", 32'(led_b), 32'(e.b));
            check("frame_start", 32'(frame_start), 32'(e.fs));
            checks++;
            if ($countones(~led_b) > 1) begin
                errors++;
                $display("FAIL b_onehot at %0t: got %b expected at most one low bit", $time, led_b);
            end
            if (e.rs) begin
                since_fs = -1;
            end else begin
                if (since_fs >= 0) since_fs++;
                if (frame_start === 1'b1) begin
                    if (since_fs >= 0) check("frame_period", 32'(since_fs), 32'(FRAME));
                    since_fs = 0;
                end
            end
        end
    end

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog at %0t: got timeout expected completion", $time);
        $fatal(1, "timeout");
    end

    localparam int RST_AT = 12 * FRAME + PHASE + 7;
    localparam int NCYC   = RST_AT + 3 * FRAME + 10;

    initial begin
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        repeat (3) @(posedge clk30);
        #1 rst = 1'b0;
        for (int c = 1; c <= NCYC; c++) begin
            cfg_we    = 1'b0;
            cfg_addr  = '0;
            cfg_wdata = '0;
            rst       = (c == RST_AT);
            if (c == 1) begin
                cfg_we = 1'b1; cfg_addr = 5'd0; cfg_wdata = 4'd8;
            end else if (c == 2) begin
                cfg_we = 1'b1; cfg_addr = 5'd20; cfg_wdata = 4'd15;
            end else if (c == 3) begin
                cfg_we = 1'b1; cfg_addr = 5'd21; cfg_wdata = 4'd5;
            end else if (c == FRAME + 9) begin
                cfg_we = 1'b1; cfg_addr = 5'd0; cfg_wdata = 4'd4;
            end else if (c == 2 * FRAME + DC) begin
                cfg_we = 1'b1; cfg_addr = 5'd0; cfg_wdata = 4'd11;
            end else if (c > 3 * FRAME && $urandom_range(0, 5) == 0) begin
                cfg_we    = 1'b1;
                cfg_addr  = AW'($urandom_range(0, 31));
                cfg_wdata = PB'($urandom_range(0, 15));
            end
            @(posedge clk30);
            #1;
        end
        cfg_we = 1'b0;
        rst    = 1'b0;
        repeat (3) @(posedge clk30);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk30);
        @(negedge clk30);
        #1;
        checks++;
        if (exp_q.size() > 1) begin
            errors++;
            $display("FAIL drain: got %0d pending expected at most 1", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
